// File: rtl/axil_native_pkg.sv
// Shared response codes, FSM state types and address decode for the AXI-Lite to native bridge.
package axil_native_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rd_state_t;

  // Upper address bits must match the window base; both arrive zero-extended to 64 bits.
  function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                     input int unsigned win_log2);
    return (addr >> win_log2) == (base >> win_log2);
  endfunction

endpackage

// File: rtl/axil_native_rd_ch.sv
// AXI-Lite read channel: decode, one-cycle native read request, data-valid wait with timeout.
module axil_native_rd_ch
  import axil_native_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter int                    WIN_LOG2   = 16,
  parameter int                    RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  rden,
  output logic [WIN_LOG2-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid
);

  localparam int ALIGN = $clog2(DATA_WIDTH/8);
  localparam int CW    = $clog2(RD_TIMEOUT+1);

  rd_state_t     state;
  logic          rdy_en;
  logic [CW-1:0] cnt;

  assign arready = rdy_en && (state == R_IDLE);
  assign rvalid  = (state == R_RESP);
  assign rden    = (state == R_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= R_IDLE;
      rdy_en <= 1'b0;
      cnt    <= '0;
      raddr  <= '0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      unique case (state)
        R_IDLE: if (arvalid && arready) begin
          raddr <= {araddr[WIN_LOG2-1:ALIGN], {ALIGN{1'b0}}};
          if (in_window(64'(araddr), 64'(ADDR_BASE), WIN_LOG2)) begin
            state <= R_REQ;
          end else begin
            rdata <= '0;
            rresp <= RESP_DECERR;
            state <= R_RESP;
          end
        end
        R_REQ: if (rd_valid) begin
          rdata <= rd_data;
          rresp <= RESP_OKAY;
          state <= R_RESP;
        end else begin
          cnt   <= '0;
          state <= R_WAIT;
        end
        // Data valid is checked before the timeout so a same-cycle return still succeeds.
        R_WAIT: if (rd_valid) begin
          rdata <= rd_data;
          rresp <= RESP_OKAY;
          state <= R_RESP;
        end else if (cnt == CW'(RD_TIMEOUT)) begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
          state <= R_RESP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        R_RESP: if (rready) state <= R_IDLE;
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave to native host-register bridge: independent AW/W capture, write FSM, read channel instance.
module axil_native_bridge
  import axil_native_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter int                    WIN_LOG2   = 16,
  parameter int                    RD_TIMEOUT = 255,
  localparam int                   STRB_W     = DATA_WIDTH/8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0]     s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  host_wren_out,
  output logic [WIN_LOG2-1:0]   host_addr_wr_out,
  output logic [DATA_WIDTH-1:0] host_data_wr_out,
  output logic [STRB_W-1:0]     host_strb_wr_out,
  output logic                  host_rden_out,
  output logic [WIN_LOG2-1:0]   host_addr_rd_out,
  input  logic [DATA_WIDTH-1:0] host_data_rd_in,
  input  logic                  host_rd_valid_in
);

  localparam int ALIGN = $clog2(STRB_W);

  wr_state_t             wst;
  logic                  rdy_en, aw_held, w_held, wr_hit;
  logic [WIN_LOG2-1:0]   wr_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs;

  // Each beat has its own holding register, so AW and W may land in any order.
  assign s_axi_awready    = rdy_en && (wst == W_COLLECT) && !aw_held;
  assign s_axi_wready     = rdy_en && (wst == W_COLLECT) && !w_held;
  assign aw_hs            = s_axi_awvalid && s_axi_awready;
  assign w_hs             = s_axi_wvalid && s_axi_wready;
  assign s_axi_bvalid     = (wst == W_RESP);
  assign s_axi_bresp      = bresp_q;
  assign host_wren_out    = (wst == W_EXEC) && wr_hit;
  assign host_addr_wr_out = wr_off;
  assign host_data_wr_out = wr_data;
  assign host_strb_wr_out = wr_strb;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wst     <= W_COLLECT;
      rdy_en  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wr_hit  <= 1'b0;
      wr_off  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      unique case (wst)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            wr_off  <= {s_axi_awaddr[WIN_LOG2-1:ALIGN], {ALIGN{1'b0}}};
            wr_hit  <= in_window(64'(s_axi_awaddr), 64'(ADDR_BASE), WIN_LOG2);
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wr_data <= s_axi_wdata;
            wr_strb <= s_axi_wstrb;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) wst <= W_EXEC;
        end
        W_EXEC: begin
          bresp_q <= wr_hit ? RESP_OKAY : RESP_DECERR;
          wst     <= W_RESP;
        end
        W_RESP: if (s_axi_bready) begin
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          wst     <= W_COLLECT;
        end
        default: wst <= W_COLLECT;
      endcase
    end
  end

  axil_native_rd_ch #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BASE (ADDR_BASE),
    .WIN_LOG2  (WIN_LOG2),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_rd (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .araddr  (s_axi_araddr),
    .arvalid (s_axi_arvalid),
    .arready (s_axi_arready),
    .rdata   (s_axi_rdata),
    .rresp   (s_axi_rresp),
    .rvalid  (s_axi_rvalid),
    .rready  (s_axi_rready),
    .rden    (host_rden_out),
    .raddr   (host_addr_rd_out),
    .rd_data (host_data_rd_in),
    .rd_valid(host_rd_valid_in)
  );

endmodule

// File: tb/tb_axil_native_bridge.sv
// Table-driven bench for axil_native_bridge with write/read scoreboards and reset corner sequence.
module tb_axil_native_bridge;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = '0, host_strb_wr_out;
  logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        host_wren_out, host_rden_out, host_rd_valid_in = 0;
  logic [15:0] host_addr_wr_out, host_addr_rd_out;
  logic [31:0] host_data_wr_out, host_data_rd_in = '0;

  axil_native_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_BASE(BASE), .WIN_LOG2(16), .RD_TIMEOUT(TO)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .host_wren_out(host_wren_out), .host_addr_wr_out(host_addr_wr_out), .host_data_wr_out(host_data_wr_out),
    .host_strb_wr_out(host_strb_wr_out), .host_rden_out(host_rden_out), .host_addr_rd_out(host_addr_rd_out),
    .host_data_rd_in(host_data_rd_in), .host_rd_valid_in(host_rd_valid_in)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {logic [15:0] off; logic [31:0] data; logic [3:0] strb;} wexp_t;
  typedef struct packed {logic [1:0] resp; logic [31:0] data;} rexp_t;
  wexp_t      wr_q[$];
  logic [1:0] b_q[$];
  rexp_t      r_q[$];
  int wren_cnt = 0, wren_cyc = -1;

  // Native write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin : wmon
    wexp_t e;
    if (host_wren_out) begin
      wren_cnt++;
      wren_cyc = cyc;
      if (wr_q.size() == 0) chk("wren_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("wren_off", host_addr_wr_out, e.off);
        chk("wren_data", host_data_wr_out, e.data);
        chk("wren_strb", host_strb_wr_out, e.strb);
      end
    end
  end

  // rd=1: d0 = valid latency after rden (-1 never), hold = rready delay.
  // rd=0: d0/d1 = AW/W start delay, hold = bready delay.
  typedef struct {bit rd; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
                  int d0; int d1; int hold; logic [1:0] resp; logic [31:0] rdata;} vec_t;
  vec_t tv[13];

  task automatic do_write(input vec_t v);
    int k = 0, n = -1, w0 = wren_cnt;
    bit aw_done = 0, w_done = 0, awf, wf;
    wexp_t e;
    e.off = v.addr[15:0] & 16'hFFFC; e.data = v.data; e.strb = v.strb;
    if (v.resp == 2'b00) wr_q.push_back(e);
    b_q.push_back(v.resp);
    while (!(aw_done && w_done) && k < 40) begin
      s_axi_awaddr = v.addr; s_axi_wdata = v.data; s_axi_wstrb = v.strb;
      s_axi_awvalid = !aw_done && k >= v.d0;
      s_axi_wvalid  = !w_done && k >= v.d1;
      if (w_done && !aw_done) chk("wready_held_low", s_axi_wready, 0);
      if (aw_done && !w_done) chk("awready_held_low", s_axi_awready, 0);
      awf = s_axi_awvalid && s_axi_awready;
      wf  = s_axi_wvalid && s_axi_wready;
      n = cyc;
      @(posedge clk); #1; k++;
      aw_done = aw_done | awf;
      w_done  = w_done | wf;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_done && w_done)) chk("aw_w_handshake", 0, 1);
    for (int j = 0; j < 20 && !s_axi_bvalid; j++) begin @(posedge clk); #1; end
    chk("bvalid_cycle", cyc, n + 2);
    chk("wren_count", wren_cnt - w0, (v.resp == 2'b00) ? 1 : 0);
    if (v.resp == 2'b00) chk("wren_cycle", wren_cyc, n + 1);
    repeat (v.hold) begin @(posedge clk); #1; chk("bvalid_hold", s_axi_bvalid, 1); end
    s_axi_bready = 1;
    chk("bresp", s_axi_bresp, b_q.pop_front());
    @(posedge clk); #1;
    s_axi_bready = 0;
    chk("bvalid_drop", s_axi_bvalid, 0);
    chk("awready_back", s_axi_awready, 1);
  endtask

  task automatic do_read(input vec_t v);
    int rv = -1, rd = -1, nrd = 0, exp_rv;
    bit done = 0;
    rexp_t re;
    re.resp = v.resp; re.data = v.rdata;
    r_q.push_back(re);
    s_axi_araddr = v.addr; s_axi_arvalid = 1;
    for (int j = 0; j < 20 && !s_axi_arready; j++) begin @(posedge clk); #1; end
    chk("arready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (host_rden_out) begin
        nrd++; rd = k;
        chk("rd_addr", host_addr_rd_out, v.addr[15:0] & 16'hFFFC);
      end
      host_rd_valid_in = (rd >= 0) && (v.d0 >= 0) && (k == rd + v.d0);
      host_data_rd_in  = host_rd_valid_in ? v.data : 32'hBAD0_BAD0;
      if (s_axi_rvalid) begin
        if (rv < 0) begin rv = k; re = r_q.pop_front(); end
        chk("rdata", s_axi_rdata, re.data);
        chk("rresp", s_axi_rresp, re.resp);
        s_axi_rready = (k - rv) >= v.hold;
      end
      @(posedge clk); #1;
      if (s_axi_rready) begin done = 1; break; end
    end
    s_axi_rready = 0; host_rd_valid_in = 0;
    if (!done) chk("r_handshake", 0, 1);
    exp_rv = (v.resp == 2'b11) ? 0 : (v.d0 >= 0 && v.d0 <= TO + 1) ? v.d0 + 1 : TO + 2;
    chk("rvalid_cycle", rv, exp_rv);
    chk("rden_count", nrd, (v.resp == 2'b11) ? 0 : 1);
    chk("rvalid_drop", s_axi_rvalid, 0);
    chk("arready_back", s_axi_arready, 1);
  endtask

  initial begin
    int seen, w0;
    tv[0]  = '{1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    tv[1]  = '{1'b0, 32'h4000_0024, 32'hCAFE_0001, 4'h3, 5, 0, 1, 2'b00, 32'h0};
    tv[2]  = '{1'b0, 32'h4000_0104, 32'h1122_3344, 4'hC, 0, 3, 0, 2'b00, 32'h0};
    tv[3]  = '{1'b0, 32'h4000_FFFC, 32'h5555_5555, 4'h0, 0, 0, 0, 2'b00, 32'h0};
    tv[4]  = '{1'b0, 32'h4000_0033, 32'h89AB_CDEF, 4'h6, 1, 1, 2, 2'b00, 32'h0};
    tv[5]  = '{1'b0, 32'h5000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 2'b11, 32'h0};
    tv[6]  = '{1'b1, 32'h4000_0008, 32'h1234_5678, 4'h0, 3, 0, 4, 2'b00, 32'h1234_5678};
    tv[7]  = '{1'b1, 32'h4000_0100, 32'hA5A5_A5A5, 4'h0, 0, 0, 0, 2'b00, 32'hA5A5_A5A5};
    tv[8]  = '{1'b1, 32'h4000_0200, 32'h7777_7777, 4'h0, -1, 0, 1, 2'b10, 32'h0};
    tv[9]  = '{1'b1, 32'h4000_0204, 32'h6666_6666, 4'h0, 6, 0, 3, 2'b10, 32'h0};
    tv[10] = '{1'b1, 32'h4000_0208, 32'h0F0F_0F0F, 4'h0, 5, 0, 0, 2'b00, 32'h0F0F_0F0F};
    tv[11] = '{1'b1, 32'h3FFF_FFFC, 32'h9999_9999, 4'h0, 1, 0, 1, 2'b11, 32'h0};
    tv[12] = '{1'b1, 32'h4000_0046, 32'h1357_9BDF, 4'h0, 1, 0, 0, 2'b00, 32'h1357_9BDF};

    #2;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, host_wren_out, host_rden_out}, 4'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    chk("ready_at_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(posedge clk); #1;
    chk("ready_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    for (int i = 0; i < 13; i++) begin
      if (tv[i].rd) do_read(tv[i]);
      else do_write(tv[i]);
    end

    // Reset while a read sits in R_WAIT and an AW beat is held without its W.
    s_axi_araddr = 32'h4000_0008; s_axi_arvalid = 1;
    s_axi_awaddr = 32'h4000_0020; s_axi_awvalid = 1;
    @(posedge clk); #1;
    s_axi_arvalid = 0; s_axi_awvalid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_awready_low", s_axi_awready, 0);
    rst_n = 0; #1;
    chk("midrst_valids", {s_axi_bvalid, s_axi_rvalid, host_wren_out, host_rden_out}, 4'b0);
    chk("midrst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    seen = 0; w0 = wren_cnt;
    repeat (8) begin
      @(posedge clk); #1;
      seen += int'(host_rden_out) + int'(s_axi_rvalid) + int'(s_axi_bvalid);
    end
    chk("post_rst_activity", seen, 0);
    chk("post_rst_wren", wren_cnt - w0, 0);
    do_write(tv[0]);
    do_read(tv[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axil_native_bridge.md
Name: axil_native_bridge

Overview:
- Parametrised successor AXI4-Lite slave to native host-register bridge, sitting between the interconnect and register banks / host-side peripherals.
- AW and W are accepted independently, in either order, and byte strobes are forwarded.
- Native reads may have variable latency via a data-valid return, with a timeout giving SLVERR.
- Addresses outside the decoded window return DECERR without touching the native bus.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- ADDR_BASE, 32'h0000_0000, base of the decoded window; aligned to 2**WIN_LOG2.
- WIN_LOG2, 16, log2 of window size in bytes; must be <= ADDR_WIDTH.
- RD_TIMEOUT, 255, maximum cycles to wait for host_rd_valid; must be >= 1.
- STRB_W (localparam), DATA_WIDTH/8.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  reset; asynchronous, active-low
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  STRB_W  write strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- host_wren_out  out  1  one-cycle native write strobe
- host_addr_wr_out  out  WIN_LOG2  window offset of write, word-aligned
- host_data_wr_out  out  DATA_WIDTH  write data
- host_strb_wr_out  out  STRB_W  byte enables
- host_rden_out  out  1  one-cycle native read request
- host_addr_rd_out  out  WIN_LOG2  window offset of read, word-aligned
- host_data_rd_in  in  DATA_WIDTH  native read data
- host_rd_valid_in  in  1  native read data valid

Behaviour:
- Reset (asynchronous, active-low, clears all state):
  - Both FSMs go to IDLE.
  - All outputs are 0 while reset is asserted, except awready, wready and arready, which rise 1 cycle after deassertion.
  - Reset mid-transaction drops the transaction. No response is issued and no native strobe is generated after release.
- Alignment and decode:
  - Native addresses carry offset = addr[WIN_LOG2-1:0] with the low log2(STRB_W) bits forced to 0.
  - An address is in range iff addr[ADDR_WIDTH-1:WIN_LOG2] == ADDR_BASE[ADDR_WIDTH-1:WIN_LOG2].
- Write FSM (W_COLLECT, W_EXEC, W_RESP):
  - W_COLLECT: awready = ~aw_held and wready = ~w_held. Each beat is captured into its own holding register on handshake.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
  - When both are held, go to W_EXEC.
  - W_EXEC (1 cycle): if in range, host_wren_out=1 with held addr/data/strb and bresp=OKAY(00). Otherwise no wren and bresp=DECERR(11). Go to W_RESP.
  - W_RESP: bvalid=1 until bready. On the handshake, clear both held flags and return to W_COLLECT.
  - Latency: AW&W handshake at cycle N -> wren at N+1 -> bvalid at N+2.
  - Only one write is outstanding; awready and wready are low from the moment their beat is held until the B handshake.
  - wstrb of all zeros is still forwarded and still gives OKAY.
- Read FSM (R_IDLE, R_REQ, R_WAIT, R_RESP):
  - R_IDLE: arready=1. On handshake, capture the address. Go to R_REQ if in range, else to R_RESP with rresp=DECERR and rdata=0.
  - R_REQ (1 cycle): host_rden_out=1. If host_rd_valid_in=1 in this same cycle, capture data with OKAY and go to R_RESP; else go to R_WAIT with the counter cleared.
  - R_WAIT: the counter increments each cycle.
    - On host_rd_valid_in: capture host_data_rd_in, rresp=OKAY, go to R_RESP.
    - If the counter reaches RD_TIMEOUT without valid: rdata=0, rresp=SLVERR(10), go to R_RESP.
    - Valid in the same cycle as the timeout wins (OKAY).
  - R_RESP: rvalid=1, and rdata/rresp stay stable until rready. Then return to R_IDLE; arready returns the next cycle.
  - host_rd_valid_in outside R_REQ/R_WAIT (late or stray) is ignored.
- Channel independence:
  - The read and write channels run independently; simultaneous wren and rden are legal.
  - awprot/arprot are not present; protection is not checked.

Decomposition:
- Package axil_native_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - typedef enums wr_state_t and rd_state_t;
  - function in_window(addr, base, win_log2).
- Natural sub-module: axil_native_rd_ch, containing the read FSM, timeout counter and R registers. The top holds the write FSM and the instance.

Test Plan:
- AW and W same cycle, addr=0x0000_0010, data=0xDEADBEEF, strb=0xF -> wren at N+1 with offset 0x10, data DEADBEEF, strb F; bvalid at N+2 with OKAY.
- W at cycle 0 (strb=0x3), AW 5 cycles later (addr 0x24) -> wready low after cycle 0; single wren with offset 0x24, strb 0x3; bresp OKAY.
- Read addr 0x8 with host_rd_valid 3 cycles after rden, data 0x12345678 -> rdata 0x12345678, OKAY; rdata held while rready=0 for 4 cycles.
- RD_TIMEOUT=4, host_rd_valid never asserted -> SLVERR with rdata 0 on the cycle after the counter reaches 4; a later stray valid is ignored.
- ADDR_BASE=0x4000_0000, WIN_LOG2=16, write 0x5000_0000 and read 0x3FFF_FFFC -> no wren/rden; bresp=DECERR and rresp=DECERR.
- axi_aresetn pulsed low during R_WAIT and after AW held -> all valids 0 immediately; no wren/rden/response after release; next transaction completes normally.
